// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1 TAP controller with a RISC-V style debug transport
// (DTMCS and DMI data registers) running entirely in the TCK domain.
//
// Configuration macro: JTAG_TAP_IDCODE_EN
//   defined   -> IR code 5'h01 selects the 32-bit IDCODE register.
//   undefined -> IR code 5'h01 behaves as BYPASS (1 bit, captures 0).
//   The reset IR value is IDCODE in both builds.
//
// DMI request handshake: o_dmi_req_valid is a level, not a pulse. It rises on
// the TCK edge leaving Update-DR and stays high until the edge that enters
// Capture-DR or Test-Logic-Reset. While it is high, o_dmi_req_addr,
// o_dmi_req_data and o_dmi_req_write are stable. The downstream side reports
// a request still in progress through i_dmi_busy; an access attempted while
// busy is dropped and recorded as sticky dmistat=3 until a DTMCS dmireset or
// dmihardreset write clears it.

module jtag_tap #(
  parameter int          abits  = 7,
  parameter int          irlen  = 5,
  parameter logic [31:0] idcode = 32'h10e31913
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_tms,
  input  logic             i_tdi,
  output logic             o_tdo,
  output logic             o_dmi_req_valid,
  output logic             o_dmi_req_write,
  output logic [abits-1:0] o_dmi_req_addr,
  output logic [31:0]      o_dmi_req_data,
  output logic             o_dmi_reset,
  output logic             o_dmi_hardreset,
  input  logic [31:0]      i_dmi_resp_data,
  input  logic             i_dmi_busy,
  output logic [3:0]       dbg_state
);

  // DMI shift register width: {addr, data[31:0], op[1:0]}
  localparam int dr_w = abits + 34;

  // Instruction codes
  localparam logic [irlen-1:0] ir_idcode = irlen'(5'h01);
  localparam logic [irlen-1:0] ir_dtmcs  = irlen'(5'h10);
  localparam logic [irlen-1:0] ir_dmi    = irlen'(5'h11);

  // Fixed DTMCS fields
  localparam logic [5:0] abits_field = 6'(abits);

  // TAP states, using the conventional 1149.1 encoding so waveforms read
  // the same as on other TAP implementations.
  typedef enum logic [3:0] {
    st_exit2_dr   = 4'h0,
    st_exit1_dr   = 4'h1,
    st_shift_dr   = 4'h2,
    st_pause_dr   = 4'h3,
    st_select_ir  = 4'h4,
    st_update_dr  = 4'h5,
    st_capture_dr = 4'h6,
    st_select_dr  = 4'h7,
    st_exit2_ir   = 4'h8,
    st_exit1_ir   = 4'h9,
    st_shift_ir   = 4'hA,
    st_pause_ir   = 4'hB,
    st_run_idle   = 4'hC,
    st_update_ir  = 4'hD,
    st_capture_ir = 4'hE,
    st_tlr        = 4'hF
  } tap_state_e;

  tap_state_e state;
  tap_state_e state_nxt;

  // Decoded per-state actions
  logic do_capture_ir;
  logic do_shift_ir;
  logic do_update_ir;
  logic do_capture_dr;
  logic do_shift_dr;
  logic do_update_dr;
  logic in_tlr;
  logic clr_req;

  // Instruction path
  logic [irlen-1:0] ir;
  logic [irlen-1:0] ir_sr;

  // Data register selection
  logic sel_idcode;
  logic sel_dtmcs;
  logic sel_dmi;

  // Shared data shift register; shorter registers use its low bits
  logic [dr_w-1:0] dr;

  // Debug transport status
  logic [1:0]       dmistat;
  logic [abits-1:0] last_addr;
  logic [31:0]      dtmcs_cap;

  // Fields of a completed DMI scan
  logic [1:0]       dmi_op;
  logic [31:0]      dmi_data;
  logic [abits-1:0] dmi_addr;

  assign dmi_op   = dr[1:0];
  assign dmi_data = dr[33:2];
  assign dmi_addr = dr[abits+33:34];

  assign dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, abits_field, 4'd1};

  // State register: TAP controller state, reset to Test-Logic-Reset
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= st_tlr;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: standard TMS-driven TAP transitions
  always_comb begin
    state_nxt = state;
    case (state)
      st_tlr:        state_nxt = i_tms ? st_tlr       : st_run_idle;
      st_run_idle:   state_nxt = i_tms ? st_select_dr : st_run_idle;
      st_select_dr:  state_nxt = i_tms ? st_select_ir : st_capture_dr;
      st_capture_dr: state_nxt = i_tms ? st_exit1_dr  : st_shift_dr;
      st_shift_dr:   state_nxt = i_tms ? st_exit1_dr  : st_shift_dr;
      st_exit1_dr:   state_nxt = i_tms ? st_update_dr : st_pause_dr;
      st_pause_dr:   state_nxt = i_tms ? st_exit2_dr  : st_pause_dr;
      st_exit2_dr:   state_nxt = i_tms ? st_update_dr : st_shift_dr;
      st_update_dr:  state_nxt = i_tms ? st_select_dr : st_run_idle;
      st_select_ir:  state_nxt = i_tms ? st_tlr       : st_capture_ir;
      st_capture_ir: state_nxt = i_tms ? st_exit1_ir  : st_shift_ir;
      st_shift_ir:   state_nxt = i_tms ? st_exit1_ir  : st_shift_ir;
      st_exit1_ir:   state_nxt = i_tms ? st_update_ir : st_pause_ir;
      st_pause_ir:   state_nxt = i_tms ? st_exit2_ir  : st_pause_ir;
      st_exit2_ir:   state_nxt = i_tms ? st_update_ir : st_shift_ir;
      st_update_ir:  state_nxt = i_tms ? st_select_dr : st_run_idle;
      default:       state_nxt = st_tlr;
    endcase
  end

  // Output logic: per-state action strobes, TDO mux and debug state
  always_comb begin
    do_capture_ir = (state == st_capture_ir);
    do_shift_ir   = (state == st_shift_ir);
    do_update_ir  = (state == st_update_ir);
    do_capture_dr = (state == st_capture_dr);
    do_shift_dr   = (state == st_shift_dr);
    do_update_dr  = (state == st_update_dr);
    in_tlr        = (state == st_tlr);
    // Request levels drop on the edge entering Capture-DR or Test-Logic-Reset
    clr_req       = (state_nxt == st_capture_dr) || (state_nxt == st_tlr);
    o_tdo         = 1'b0;
    if (do_shift_ir) begin
      o_tdo = ir_sr[0];
    end else if (do_shift_dr) begin
      o_tdo = dr[0];
    end
    dbg_state     = state;
  end

  // Instruction decode; unknown codes fall through to BYPASS
  always_comb begin
`ifdef JTAG_TAP_IDCODE_EN
    sel_idcode = (ir == ir_idcode);
`else
    sel_idcode = 1'b0;
`endif
    sel_dtmcs  = (ir == ir_dtmcs);
    sel_dmi    = (ir == ir_dmi);
  end

  // Instruction register and its shift register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ir    <= ir_idcode;
      ir_sr <= '0;
    end else begin
      if (in_tlr) begin
        ir <= ir_idcode;
      end else if (do_update_ir) begin
        ir <= ir_sr;
      end
      if (do_capture_ir) begin
        ir_sr <= irlen'(1);
      end else if (do_shift_ir) begin
        ir_sr <= {i_tdi, ir_sr[irlen-1:1]};
      end
    end
  end

  // Data shift register: capture the selected register, then shift right
  // with TDI entering at the MSB of the selected length
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      dr <= '0;
    end else if (do_capture_dr) begin
      if (sel_dmi) begin
        dr <= {last_addr, i_dmi_resp_data, dmistat};
      end else if (sel_dtmcs) begin
        dr <= dr_w'(dtmcs_cap);
      end else if (sel_idcode) begin
        dr <= dr_w'(idcode);
      end else begin
        dr <= '0;
      end
    end else if (do_shift_dr) begin
      if (sel_dmi) begin
        dr <= {i_tdi, dr[dr_w-1:1]};
      end else if (sel_dtmcs || sel_idcode) begin
        dr[31:0] <= {i_tdi, dr[31:1]};
      end else begin
        dr[0] <= i_tdi;
      end
    end
  end

  // DMI request generation, sticky error status and DTMCS reset requests
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_dmi_req_valid <= 1'b0;
      o_dmi_req_write <= 1'b0;
      o_dmi_req_addr  <= '0;
      o_dmi_req_data  <= '0;
      o_dmi_reset     <= 1'b0;
      o_dmi_hardreset <= 1'b0;
      dmistat         <= 2'd0;
      last_addr       <= '0;
    end else begin
      if (clr_req) begin
        o_dmi_req_valid <= 1'b0;
        o_dmi_reset     <= 1'b0;
        o_dmi_hardreset <= 1'b0;
      end
      if (do_update_dr) begin
        if (sel_dmi) begin
          // A pending error blocks new accesses until it is cleared via DTMCS
          if ((dmistat == 2'd0) && ((dmi_op == 2'd1) || (dmi_op == 2'd2))) begin
            if (i_dmi_busy) begin
              dmistat <= 2'd3;
            end else begin
              o_dmi_req_valid <= 1'b1;
              o_dmi_req_write <= (dmi_op == 2'd2);
              o_dmi_req_addr  <= dmi_addr;
              o_dmi_req_data  <= dmi_data;
              last_addr       <= dmi_addr;
            end
          end
        end else if (sel_dtmcs) begin
          if (dr[16] || dr[17]) begin
            dmistat         <= 2'd0;
            o_dmi_req_valid <= 1'b1;
            o_dmi_req_write <= 1'b0;
          end
          if (dr[16]) begin
            o_dmi_reset <= 1'b1;
          end
          if (dr[17]) begin
            o_dmi_hardreset <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// tb_jtag_tap: directed-vector bench for jtag_tap with hand-computed
// expected values (abits=7, irlen=5).

module tb_jtag_tap;

  localparam int          abits  = 7;
  localparam int          irlen  = 5;
  localparam logic [31:0] idcode = 32'h10e31913;

  localparam logic [3:0] st_tlr      = 4'hF;
  localparam logic [3:0] st_run_idle = 4'hC;
  localparam logic [3:0] st_pause_ir = 4'hB;
  localparam logic [3:0] st_select_dr  = 4'h7;
  localparam logic [3:0] st_capture_dr = 4'h6;

  localparam logic [31:0] resp = 32'hCAFEBABE;

  logic             i_clk;
  logic             i_nrst;
  logic             i_tms;
  logic             i_tdi;
  logic             o_tdo;
  logic             o_dmi_req_valid;
  logic             o_dmi_req_write;
  logic [abits-1:0] o_dmi_req_addr;
  logic [31:0]      o_dmi_req_data;
  logic             o_dmi_reset;
  logic             o_dmi_hardreset;
  logic [31:0]      i_dmi_resp_data;
  logic             i_dmi_busy;
  logic [3:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  jtag_tap #(
    .abits  (abits),
    .irlen  (irlen),
    .idcode (idcode)
  ) dut (
    .i_clk           (i_clk),
    .i_nrst          (i_nrst),
    .i_tms           (i_tms),
    .i_tdi           (i_tdi),
    .o_tdo           (o_tdo),
    .o_dmi_req_valid (o_dmi_req_valid),
    .o_dmi_req_write (o_dmi_req_write),
    .o_dmi_req_addr  (o_dmi_req_addr),
    .o_dmi_req_data  (o_dmi_req_data),
    .o_dmi_reset     (o_dmi_reset),
    .o_dmi_hardreset (o_dmi_hardreset),
    .i_dmi_resp_data (i_dmi_resp_data),
    .i_dmi_busy      (i_dmi_busy),
    .dbg_state       (dbg_state)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One TCK cycle: drive after the falling edge, sample TDO before the rising edge
  task automatic step(input logic tms, input logic tdi, output logic tdo_bit);
    @(negedge i_clk);
    i_tms = tms;
    i_tdi = tdi;
    #1;
    tdo_bit = o_tdo;
    @(posedge i_clk);
    #1;
  endtask

  task automatic move(input logic tms);
    logic t;
    step(tms, 1'b0, t);
  endtask

  // Any state -> Test-Logic-Reset -> Run-Test/Idle
  task automatic reset_tap();
    for (int i = 0; i < 5; i++) move(1'b1);
    move(1'b0);
  endtask

  // Run-Test/Idle -> IR scan -> Run-Test/Idle; returns captured IR bits
  task automatic shift_ir(input logic [irlen-1:0] v, output logic [irlen-1:0] cap);
    logic t;
    move(1'b1);
    move(1'b1);
    move(1'b0);
    move(1'b0);
    for (int i = 0; i < irlen; i++) begin
      step(i == irlen - 1, v[i], t);
      cap[i] = t;
    end
    move(1'b1);
    move(1'b0);
  endtask

  // Run-Test/Idle -> DR scan of len bits -> Run-Test/Idle (via Update-DR)
  task automatic shift_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
    logic t;
    dout = '0;
    move(1'b1);
    move(1'b0);
    move(1'b0);
    for (int i = 0; i < len; i++) begin
      step(i == len - 1, din[i], t);
      dout[i] = t;
    end
    move(1'b1);
    move(1'b0);
  endtask

  initial begin
    logic [63:0]      dout;
    logic [irlen-1:0] irc;
    logic             t;

    i_nrst          = 1'b0;
    i_tms           = 1'b1;
    i_tdi           = 1'b0;
    i_dmi_resp_data = resp;
    i_dmi_busy      = 1'b0;

    // Reset state
    #12;
    check("rst_state", 64'(dbg_state), 64'(st_tlr));
    check("rst_valid", 64'(o_dmi_req_valid), 64'd0);
    check("rst_write", 64'(o_dmi_req_write), 64'd0);
    check("rst_addr", 64'(o_dmi_req_addr), 64'd0);
    check("rst_data", 64'(o_dmi_req_data), 64'd0);
    check("rst_dmireset", 64'(o_dmi_reset), 64'd0);
    check("rst_hardreset", 64'(o_dmi_hardreset), 64'd0);
    check("rst_tdo", 64'(o_tdo), 64'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;

    reset_tap();
    check("idle_state", 64'(dbg_state), 64'(st_run_idle));

    // IDCODE read straight after reset
    shift_dr(64'd0, 32, dout);
`ifdef JTAG_TAP_IDCODE_EN
    check("idcode_read", dout[31:0], 64'(idcode));
`else
    check("idcode_bypass_bit0", 64'(dout[0]), 64'd0);
`endif

    // DTMCS read
    shift_ir(5'h10, irc);
    check("ir_capture", 64'(irc), 64'd1);
    shift_dr(64'd0, 32, dout);
    check("dtmcs_read", dout, 64'h0000_1071);
    check("dtmcs_nop_valid", 64'(o_dmi_req_valid), 64'd0);

    // DMI write addr=0x10 data=1 op=2
    shift_ir(5'h11, irc);
    shift_dr({23'd0, 7'h10, 32'h1, 2'd2}, 41, dout);
    check("dmi_cap0", dout, {23'd0, 7'h00, resp, 2'd0});
    check("dmiw_valid", 64'(o_dmi_req_valid), 64'd1);
    check("dmiw_write", 64'(o_dmi_req_write), 64'd1);
    check("dmiw_addr", 64'(o_dmi_req_addr), 64'h10);
    check("dmiw_data", 64'(o_dmi_req_data), 64'h1);

    // Valid held through Select-DR, dropped on entering Capture-DR
    move(1'b1);
    check("sel_dr_state", 64'(dbg_state), 64'(st_select_dr));
    check("valid_held", 64'(o_dmi_req_valid), 64'd1);
    move(1'b0);
    check("cap_dr_state", 64'(dbg_state), 64'(st_capture_dr));
    check("valid_cleared", 64'(o_dmi_req_valid), 64'd0);
    move(1'b1);
    move(1'b1);
    move(1'b0);
    check("op0_no_valid", 64'(o_dmi_req_valid), 64'd0);

    // DMI read addr=0x22 op=1; capture shows last_addr=0x10
    shift_dr({23'd0, 7'h22, 32'h0, 2'd1}, 41, dout);
    check("dmi_cap_last", dout, {23'd0, 7'h10, resp, 2'd0});
    check("dmir_valid", 64'(o_dmi_req_valid), 64'd1);
    check("dmir_write", 64'(o_dmi_req_write), 64'd0);
    check("dmir_addr", 64'(o_dmi_req_addr), 64'h22);
    check("dmir_data", 64'(o_dmi_req_data), 64'h0);

    // Busy: access dropped, sticky dmistat=3
    i_dmi_busy = 1'b1;
    shift_dr({23'd0, 7'h05, 32'h0, 2'd1}, 41, dout);
    check("busy_cap", dout, {23'd0, 7'h22, resp, 2'd0});
    check("busy_no_valid", 64'(o_dmi_req_valid), 64'd0);
    i_dmi_busy = 1'b0;
    shift_dr({23'd0, 7'h06, 32'h55, 2'd2}, 41, dout);
    check("sticky_cap", dout, {23'd0, 7'h22, resp, 2'd3});
    check("sticky_no_valid", 64'(o_dmi_req_valid), 64'd0);
    shift_dr(64'd0, 41, dout);
    check("sticky_cap2", dout, {23'd0, 7'h22, resp, 2'd3});

    // DTMCS dmireset clears dmistat
    shift_ir(5'h10, irc);
    shift_dr(64'h1_0000, 32, dout);
    check("dtmcs_err_read", dout, 64'h0000_1C71);
    check("dmireset_set", 64'(o_dmi_reset), 64'd1);
    check("dmireset_valid", 64'(o_dmi_req_valid), 64'd1);
    check("dmireset_write", 64'(o_dmi_req_write), 64'd0);
    shift_dr(64'h2_0000, 32, dout);
    check("dtmcs_clear_read", dout, 64'h0000_1071);
    check("hardreset_set", 64'(o_dmi_hardreset), 64'd1);
    check("dmireset_dropped", 64'(o_dmi_reset), 64'd0);
    check("hardreset_valid", 64'(o_dmi_req_valid), 64'd1);

    // Park in Pause-IR, then five TMS=1 reach Test-Logic-Reset
    move(1'b1);
    move(1'b1);
    move(1'b0);
    move(1'b1);
    move(1'b0);
    check("pause_ir_state", 64'(dbg_state), 64'(st_pause_ir));
    check("pause_valid_held", 64'(o_dmi_req_valid), 64'd1);
    for (int i = 0; i < 5; i++) move(1'b1);
    check("tms5_state", 64'(dbg_state), 64'(st_tlr));
    check("tlr_valid", 64'(o_dmi_req_valid), 64'd0);
    check("tlr_hardreset", 64'(o_dmi_hardreset), 64'd0);
    move(1'b0);

    // Unknown IR -> 1-bit bypass, TDO is TDI delayed one cycle
    shift_ir(5'h05, irc);
    check("ir_capture2", 64'(irc), 64'd1);
    shift_dr(64'hB2, 8, dout);
    check("bypass_shift", dout, 64'h64);

    // Reset asserted in the middle of a DMI write scan
    shift_ir(5'h11, irc);
    move(1'b1);
    move(1'b0);
    move(1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, i[0], t);
    @(negedge i_clk);
    #2;
    i_nrst = 1'b0;
    #1;
    check("midrst_state", 64'(dbg_state), 64'(st_tlr));
    check("midrst_valid", 64'(o_dmi_req_valid), 64'd0);
    check("midrst_tdo", 64'(o_tdo), 64'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    move(1'b0);
    check("midrst_idle_valid", 64'(o_dmi_req_valid), 64'd0);
    // IR back to IDCODE: 32-bit IDCODE, or 1-bit bypass in the default build
    shift_dr(64'hA5A5_0F0F, 32, dout);
`ifdef JTAG_TAP_IDCODE_EN
    check("midrst_ir_idcode", dout, 64'(idcode));
`else
    check("midrst_ir_idcode", dout, 64'h4B4A_1E1E);
`endif
    check("midrst_final_valid", 64'(o_dmi_req_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
